// File: rtl/mrv1_pkg.sv
// Shared constants and the writeback entry type for the MRV1 writeback path.
// Widths here are the defaults the writeback arbiter is built around.
package mrv1_pkg;

  localparam int unsigned NUM_THREADS   = 8;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned TID_WIDTH     = $clog2(NUM_THREADS);

  typedef struct packed {
    logic                     we;
    logic [RF_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/mrv1_rr_arbiter.sv
// Pointer-based round-robin picker: first requester at or after ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module mrv1_rr_arbiter #(
  parameter int NUM_REQ_P = 8
) (
  input  logic [NUM_REQ_P-1:0]         req_i,
  input  logic [$clog2(NUM_REQ_P)-1:0] ptr_i,
  output logic [NUM_REQ_P-1:0]         gnt_o
);

  logic found;

  // Walk offsets from the pointer; constant inner index keeps selects static.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ_P; off++) begin
      for (int j = 0; j < NUM_REQ_P; j++) begin
        if (!found && req_i[j] && (((int'(ptr_i) + off) % NUM_REQ_P) == j)) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mrv1_wb_arbiter.sv
// Per-thread writeback arbiter: round-robin with an aging override feeding a
// single registered output stage with valid/ready handshake.
module mrv1_wb_arbiter
  import mrv1_pkg::*;
#(
  parameter int unsigned NUM_THREADS_P   = NUM_THREADS,
  parameter int unsigned DATA_WIDTH_P    = DATA_WIDTH,
  parameter int unsigned rf_addr_width_p = RF_ADDR_WIDTH,
  parameter int unsigned AGE_LIMIT_P     = 15
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NUM_THREADS_P-1:0]                  req_vld_i,
  input  logic [NUM_THREADS_P-1:0]                  req_we_i,
  input  logic [NUM_THREADS_P*rf_addr_width_p-1:0]  req_rd_addr_i,
  input  logic [NUM_THREADS_P*DATA_WIDTH_P-1:0]     req_data_i,
  input  logic [NUM_THREADS_P-1:0]                  thread_en_i,
  input  logic [NUM_THREADS_P-1:0]                  flush_i,
  output logic [NUM_THREADS_P-1:0]                  req_gnt_o,
  output logic                                      wb_vld_o,
  output logic                                      wb_we_o,
  output logic [$clog2(NUM_THREADS_P)-1:0]          wb_tid_o,
  output logic [rf_addr_width_p-1:0]                wb_rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]                   wb_data_o,
  input  logic                                      wb_rdy_i
);

  localparam int unsigned TID_W = $clog2(NUM_THREADS_P);
  localparam int unsigned CNT_W = $clog2(AGE_LIMIT_P + 1);
  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(AGE_LIMIT_P);
  localparam logic [NUM_THREADS_P-1:0] ONE = NUM_THREADS_P'(1);

  logic [NUM_THREADS_P-1:0] elig, aged, aged_gnt, rr_gnt, gnt;
  logic                     adv;
  logic [TID_W-1:0]         gnt_tid;
  wb_req_t                  gnt_entry;
  logic [TID_W-1:0]         rr_q, rr_d;
  logic [CNT_W-1:0]         wait_q [NUM_THREADS_P];
  logic [CNT_W-1:0]         wait_d [NUM_THREADS_P];
  logic                     wb_vld_q, wb_vld_d;
  logic [TID_W-1:0]         wb_tid_q, wb_tid_d;
  wb_req_t                  entry_q, entry_d;

  assign elig = req_vld_i & thread_en_i & ~flush_i;
  assign adv  = ~wb_vld_q | wb_rdy_i;

  mrv1_rr_arbiter #(
    .NUM_REQ_P (NUM_THREADS_P)
  ) u_rr_arbiter (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (rr_gnt)
  );

  // Aged threads preempt round-robin, lowest index first; no grant during reset.
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      aged[i] = elig[i] && (wait_q[i] == AGE_MAX);
    end
    aged_gnt = aged & (~aged + ONE);
    gnt = '0;
    if (adv && rst_ni) begin
      gnt = (|aged) ? aged_gnt : rr_gnt;
    end
    gnt_tid   = '0;
    gnt_entry = '0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      if (gnt[i]) begin
        gnt_tid           = TID_W'(i);
        gnt_entry.we      = req_we_i[i];
        gnt_entry.rd_addr = req_rd_addr_i[i*rf_addr_width_p +: rf_addr_width_p];
        gnt_entry.data    = req_data_i[i*DATA_WIDTH_P +: DATA_WIDTH_P];
      end
    end
  end

  assign req_gnt_o = gnt;

  always_comb begin
    rr_d = rr_q;
    if (|gnt) begin
      rr_d = (gnt_tid == TID_W'(NUM_THREADS_P - 1)) ? '0 : gnt_tid + 1'b1;
    end
    // A disabled thread keeps its count; losing while eligible ages it.
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      wait_d[i] = wait_q[i];
      if (gnt[i] || flush_i[i] || !req_vld_i[i]) begin
        wait_d[i] = '0;
      end else if (elig[i] && (wait_q[i] != AGE_MAX)) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
    wb_vld_d = wb_vld_q;
    wb_tid_d = wb_tid_q;
    entry_d  = entry_q;
    if (adv) begin
      wb_vld_d = |gnt;
      if (|gnt) begin
        wb_tid_d = gnt_tid;
        entry_d  = gnt_entry;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wb_vld_q <= 1'b0;
      wb_tid_q <= '0;
      entry_q  <= '0;
      for (int i = 0; i < NUM_THREADS_P; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      wb_vld_q <= wb_vld_d;
      wb_tid_q <= wb_tid_d;
      entry_q  <= entry_d;
      for (int i = 0; i < NUM_THREADS_P; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign wb_vld_o     = wb_vld_q;
  assign wb_we_o      = entry_q.we;
  assign wb_tid_o     = wb_tid_q;
  assign wb_rd_addr_o = entry_q.rd_addr;
  assign wb_data_o    = entry_q.data;

endmodule

// File: tb/tb_mrv1_wb_arbiter.sv
// Directed self-checking bench for mrv1_wb_arbiter: a default instance plus a
// short-age instance sharing the same stimulus.
module tb_mrv1_wb_arbiter;

  logic         clk;
  logic         rst_n;
  logic [7:0]   req_vld;
  logic [7:0]   req_we;
  logic [39:0]  rd_addr;
  logic [255:0] data;
  logic [7:0]   thread_en;
  logic [7:0]   flush;
  logic         rdy;

  logic [7:0]   gnt, gnt_age;
  logic         wb_vld, wb_vld_age;
  logic         wb_we, wb_we_age;
  logic [2:0]   wb_tid, wb_tid_age;
  logic [4:0]   wb_addr, wb_addr_age;
  logic [31:0]  wb_data, wb_data_age;

  int passed;
  int total;
  int errors;

  mrv1_wb_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_vld_i     (req_vld),
    .req_we_i      (req_we),
    .req_rd_addr_i (rd_addr),
    .req_data_i    (data),
    .thread_en_i   (thread_en),
    .flush_i       (flush),
    .req_gnt_o     (gnt),
    .wb_vld_o      (wb_vld),
    .wb_we_o       (wb_we),
    .wb_tid_o      (wb_tid),
    .wb_rd_addr_o  (wb_addr),
    .wb_data_o     (wb_data),
    .wb_rdy_i      (rdy)
  );

  mrv1_wb_arbiter #(
    .AGE_LIMIT_P (2)
  ) dut_age (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_vld_i     (req_vld),
    .req_we_i      (req_we),
    .req_rd_addr_i (rd_addr),
    .req_data_i    (data),
    .thread_en_i   (thread_en),
    .flush_i       (flush),
    .req_gnt_o     (gnt_age),
    .wb_vld_o      (wb_vld_age),
    .wb_we_o       (wb_we_age),
    .wb_tid_o      (wb_tid_age),
    .wb_rd_addr_o  (wb_addr_age),
    .wb_data_o     (wb_data_age),
    .wb_rdy_i      (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Thread i carries addr i+10, data 0x1000_000i; thread 3 is retire-only.
  task automatic load_payload();
    for (int i = 0; i < 8; i++) begin
      data[i*32 +: 32]  = 32'h1000_0000 + i;
      rd_addr[i*5 +: 5] = 5'(i + 10);
    end
    req_we = 8'hF7;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_vld   = '0;
    flush     = '0;
    thread_en = 8'hFF;
    rdy       = 1'b1;
    load_payload();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    load_payload();
    req_vld   = 8'hFF;
    thread_en = 8'hFF;
    flush     = '0;
    rdy       = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_gnt: got %h want 00", gnt); end else passed++;
    total++; if (gnt_age !== 8'h00) begin errors++; $display("[TB] FAIL reset_gnt_age: got %h want 00", gnt_age); end else passed++;
    total++; if (wb_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b want 0", wb_vld); end else passed++;
    total++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", wb_we); end else passed++;
    total++; if (wb_tid !== 3'd0) begin errors++; $display("[TB] FAIL reset_tid: got %0d want 0", wb_tid); end else passed++;
    total++; if (wb_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", wb_addr); end else passed++;
    total++; if (wb_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", wb_data); end else passed++;
    req_vld = '0;
  endtask

  task automatic test_round_robin();
    int exp_tid [6] = '{0, 3, 5, 0, 3, 5};
    apply_reset();
    req_vld = 8'b0010_1001;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (gnt !== (8'h01 << exp_tid[c])) begin errors++; $display("[TB] FAIL rr_gnt[%0d]: got %h want %h", c, gnt, 8'h01 << exp_tid[c]); end else passed++;
      tick();
      total++; if (wb_vld !== 1'b1) begin errors++; $display("[TB] FAIL rr_vld[%0d]: got %b want 1", c, wb_vld); end else passed++;
      total++; if (wb_tid !== 3'(exp_tid[c])) begin errors++; $display("[TB] FAIL rr_tid[%0d]: got %0d want %0d", c, wb_tid, exp_tid[c]); end else passed++;
      total++; if (wb_data !== 32'h1000_0000 + exp_tid[c]) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", c, wb_data, 32'h1000_0000 + exp_tid[c]); end else passed++;
      total++; if (wb_addr !== 5'(exp_tid[c] + 10)) begin errors++; $display("[TB] FAIL rr_addr[%0d]: got %h want %h", c, wb_addr, 5'(exp_tid[c] + 10)); end else passed++;
      total++; if (wb_we !== (exp_tid[c] != 3)) begin errors++; $display("[TB] FAIL rr_we[%0d]: got %b want %b", c, wb_we, exp_tid[c] != 3); end else passed++;
    end
    req_vld = '0;
  endtask

  task automatic test_wrap();
    apply_reset();
    req_vld = 8'h40;
    #1;
    total++; if (gnt !== 8'h40) begin errors++; $display("[TB] FAIL wrap_setup: got %h want 40", gnt); end else passed++;
    tick();
    req_vld = 8'h82;
    #1;
    total++; if (gnt !== 8'h80) begin errors++; $display("[TB] FAIL wrap_first: got %h want 80", gnt); end else passed++;
    tick();
    total++; if (wb_tid !== 3'd7) begin errors++; $display("[TB] FAIL wrap_tid7: got %0d want 7", wb_tid); end else passed++;
    #1;
    total++; if (gnt !== 8'h02) begin errors++; $display("[TB] FAIL wrap_second: got %h want 02", gnt); end else passed++;
    tick();
    total++; if (wb_tid !== 3'd1) begin errors++; $display("[TB] FAIL wrap_tid1: got %0d want 1", wb_tid); end else passed++;
    req_vld = '0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rd_addr[2*5 +: 5]  = 5'd5;
    data[2*32 +: 32]   = 32'hDEAD_BEEF;
    req_vld            = 8'h04;
    #1;
    total++; if (gnt !== 8'h04) begin errors++; $display("[TB] FAIL bp_grant: got %h want 04", gnt); end else passed++;
    tick();
    req_vld = 8'h08;
    rdy     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL bp_stall_gnt[%0d]: got %h want 00", c, gnt); end else passed++;
      total++; if ({wb_vld, wb_we, wb_tid, wb_addr, wb_data} !== {1'b1, 1'b1, 3'd2, 5'd5, 32'hDEAD_BEEF}) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: got vld=%b we=%b tid=%0d addr=%h data=%h want 1 1 2 05 deadbeef", c, wb_vld, wb_we, wb_tid, wb_addr, wb_data);
      end else passed++;
      tick();
    end
    rdy = 1'b1;
    #1;
    total++; if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL bp_release_gnt: got %h want 08", gnt); end else passed++;
    tick();
    total++; if ({wb_vld, wb_tid} !== {1'b1, 3'd3}) begin errors++; $display("[TB] FAIL bp_next: got vld=%b tid=%0d want 1 3", wb_vld, wb_tid); end else passed++;
    req_vld = '0;
    #1;
    total++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL bp_idle_gnt: got %h want 00", gnt); end else passed++;
    tick();
    total++; if (wb_vld !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b want 0", wb_vld); end else passed++;
  endtask

  task automatic test_aging();
    apply_reset();
    thread_en = 8'h3F;
    req_vld   = 8'h41;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (gnt_age !== 8'h01) begin errors++; $display("[TB] FAIL age_frozen[%0d]: got %h want 01", c, gnt_age); end else passed++;
      tick();
    end
    thread_en = 8'hFF;
    req_vld   = 8'h42;
    #1;
    total++; if (gnt_age !== 8'h02) begin errors++; $display("[TB] FAIL age_c0: got %h want 02", gnt_age); end else passed++;
    tick();
    req_vld = 8'h44;
    #1;
    total++; if (gnt_age !== 8'h04) begin errors++; $display("[TB] FAIL age_c1: got %h want 04", gnt_age); end else passed++;
    tick();
    req_vld = 8'h48;
    #1;
    total++; if (gnt_age !== 8'h40) begin errors++; $display("[TB] FAIL age_override: got %h want 40", gnt_age); end else passed++;
    total++; if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL age_default_rr: got %h want 08", gnt); end else passed++;
    tick();
    total++; if (wb_tid_age !== 3'd6) begin errors++; $display("[TB] FAIL age_tid: got %0d want 6", wb_tid_age); end else passed++;
    req_vld = 8'h09;
    #1;
    total++; if (gnt_age !== 8'h01) begin errors++; $display("[TB] FAIL age_rr_update: got %h want 01", gnt_age); end else passed++;
    tick();
    req_vld = '0;
  endtask

  task automatic test_flush();
    apply_reset();
    req_vld = 8'h10;
    flush   = 8'h10;
    #1;
    total++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL flush_suppress: got %h want 00", gnt); end else passed++;
    tick();
    total++; if (wb_vld !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_entry: got %b want 0", wb_vld); end else passed++;
    flush = '0;
    #1;
    total++; if (gnt !== 8'h10) begin errors++; $display("[TB] FAIL flush_grant: got %h want 10", gnt); end else passed++;
    tick();
    rdy   = 1'b0;
    flush = 8'h10;
    #1;
    total++; if ({wb_vld, wb_tid, wb_data} !== {1'b1, 3'd4, 32'h1000_0004}) begin errors++; $display("[TB] FAIL flush_entry: got vld=%b tid=%0d data=%h want 1 4 10000004", wb_vld, wb_tid, wb_data); end else passed++;
    tick();
    total++; if ({wb_vld, wb_tid} !== {1'b1, 3'd4}) begin errors++; $display("[TB] FAIL flush_kept: got vld=%b tid=%0d want 1 4", wb_vld, wb_tid); end else passed++;
    rdy = 1'b1;
    #1;
    total++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL flush_drain_gnt: got %h want 00", gnt); end else passed++;
    tick();
    total++; if (wb_vld !== 1'b0) begin errors++; $display("[TB] FAIL flush_drained: got %b want 0", wb_vld); end else passed++;
    flush   = '0;
    req_vld = '0;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    req_vld = 8'h08;
    #1;
    total++; if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL rst_setup: got %h want 08", gnt); end else passed++;
    tick();
    req_vld = 8'h29;
    rdy     = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++; if ({wb_vld, wb_tid, wb_addr, wb_data} !== {1'b0, 3'd0, 5'd0, 32'd0}) begin errors++; $display("[TB] FAIL rst_async: got vld=%b tid=%0d addr=%h data=%h want 0 0 00 00000000", wb_vld, wb_tid, wb_addr, wb_data); end else passed++;
    total++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL rst_gnt: got %h want 00", gnt); end else passed++;
    #2 rst_n = 1'b1;
    rdy = 1'b1;
    #1;
    total++; if (gnt !== 8'h01) begin errors++; $display("[TB] FAIL rst_restart: got %h want 01", gnt); end else passed++;
    tick();
    total++; if ({wb_vld, wb_tid} !== {1'b1, 3'd0}) begin errors++; $display("[TB] FAIL rst_first_wb: got vld=%b tid=%0d want 1 0", wb_vld, wb_tid); end else passed++;
    #1;
    total++; if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL rst_second: got %h want 08", gnt); end else passed++;
    tick();
    req_vld = '0;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    errors    = 0;
    rst_n     = 1'b1;
    req_vld   = '0;
    req_we    = '0;
    rd_addr   = '0;
    data      = '0;
    thread_en = '0;
    flush     = '0;
    rdy       = 1'b1;
    test_reset();
    test_round_robin();
    test_wrap();
    test_back_to_back();
    test_aging();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mrv1_wb_arbiter.md
MRV1_WB_ARBITER -- requirements
Module: mrv1_wb_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_THREADS_P, default 8: number of hardware threads (requesters).
REQ-002 The module SHALL have parameter DATA_WIDTH_P, default 32: writeback data width.
REQ-003 The module SHALL have parameter rf_addr_width_p, default 5: register-file address width.
REQ-004 The module SHALL have parameter AGE_LIMIT_P, default 15: wait cycles before a thread is promoted to aged priority.
REQ-005 The module SHALL use one clock and an asynchronous, active-low reset, with ports `clk_i` (input, 1 bit, clock) and `rst_ni` (input, 1 bit, reset).
REQ-006 The module SHALL have the following ports, one per line: name, direction, width, meaning.
  - `req_vld_i`, input, NUM_THREADS_P: per-thread writeback request.
  - `req_we_i`, input, NUM_THREADS_P: request carries a register write (0 = retire-only slot).
  - `req_rd_addr_i`, input, NUM_THREADS_P x rf_addr_width_p: destination register.
  - `req_data_i`, input, NUM_THREADS_P x DATA_WIDTH_P: writeback data.
  - `thread_en_i`, input, NUM_THREADS_P: thread eligible for grant.
  - `flush_i`, input, NUM_THREADS_P: per-thread flush.
  - `req_gnt_o`, output, NUM_THREADS_P: one-hot grant, combinational.
  - `wb_vld_o`, output, 1: registered writeback valid.
  - `wb_we_o`, output, 1: registered write enable.
  - `wb_tid_o`, output, clog2(NUM_THREADS_P): granted thread id.
  - `wb_rd_addr_o`, output, rf_addr_width_p: registered destination.
  - `wb_data_o`, output, DATA_WIDTH_P: registered data.
  - `wb_rdy_i`, input, 1: register-file port accepts the output this cycle.

Function
REQ-007 Thread i SHALL be eligible when req_vld_i[i] & thread_en_i[i] & ~flush_i[i].
REQ-008 Grant SHALL be allowed (adv) only when the output stage is empty (~wb_vld_o) or draining (wb_rdy_i).
REQ-009 req_gnt_o SHALL be zero or one-hot, and nonzero only when adv is high and at least one thread is eligible.
REQ-010 Round-robin: the eligible thread at or after pointer rr_q in increasing index order, with wrap from NUM_THREADS_P-1 to 0, SHALL win.
REQ-011 On a grant to thread k, rr_q SHALL become (k+1) mod NUM_THREADS_P on the next edge; with no grant, rr_q SHALL hold.
REQ-012 Aging: each thread SHALL keep a wait counter, saturating at AGE_LIMIT_P, that increments each cycle the thread is eligible but not granted.
REQ-013 A thread's wait counter SHALL clear on that thread's grant, on its flush_i, or on req_vld_i low.
REQ-014 If any eligible thread's counter equals AGE_LIMIT_P, the lowest-index such thread SHALL win, overriding round-robin, and rr_q SHALL still update per REQ-011.
REQ-015 Latency: a grant in cycle t SHALL make wb_* reflect the granted thread's tid, we, addr and data from cycle t+1.
REQ-016 Handshake: the output SHALL be consumed on wb_vld_o & wb_rdy_i.
REQ-017 While wb_vld_o & ~wb_rdy_i, all wb_* outputs SHALL hold stable and req_gnt_o SHALL be 0.
REQ-018 Consume without a new grant SHALL clear wb_vld_o next cycle.
REQ-019 Consume with a new grant SHALL load the new entry with no bubble (full throughput of 1 per cycle).
REQ-020 Requesters SHALL hold req_* stable until granted; the arbiter does not buffer ungranted requests.
REQ-021 flush_i[i] SHALL suppress a grant to thread i in the same cycle.
REQ-022 flush_i[i] SHALL NOT cancel an entry for thread i already in the output register; that entry drains normally.
REQ-023 thread_en_i low SHALL freeze the thread's wait counter.
REQ-024 wb_rd_addr_o and wb_data_o SHALL be don't-care when wb_we_o = 0, but SHALL still be registered.

Reset
REQ-025 On rst_ni low, asynchronously: wb_vld_o = 0, wb_we_o = 0, wb_tid_o = 0, wb_rd_addr_o = 0, wb_data_o = 0, rr_q = 0, all wait counters = 0.
REQ-026 req_gnt_o SHALL be 0 while reset is asserted.
REQ-027 Reset asserted mid-stall SHALL drop the held entry with no writeback.
REQ-028 The first grant after reset deassertion SHALL be possible in the first clock cycle.

Structure
REQ-029 The tid width constant and a wb_req_t struct {we, rd_addr, data} SHALL reside in mrv1_pkg.
REQ-030 The pointer-based round-robin selection SHALL be a sub-module mrv1_rr_arbiter (inputs: req vector, pointer; output: one-hot grant).
REQ-031 Aging override, counters and the output register SHALL remain in mrv1_wb_arbiter.

Verification
REQ-032 Threads 0, 3 and 5 request continuously with wb_rdy_i = 1 -> grants SHALL be 0, 3, 5, 0, 3, 5 on consecutive cycles, and wb_vld_o SHALL stay 1.
REQ-033 Wrap-around: rr_q = 7 and threads 1 and 7 request -> grant 7, then 1.
REQ-034 Backpressure: grant thread 2 (addr 5, data 0xDEADBEEF), then wb_rdy_i = 0 for 3 cycles -> outputs SHALL be stable and req_gnt_o = 0, and a single writeback SHALL occur when wb_rdy_i rises.
REQ-035 Aging: AGE_LIMIT_P = 2, thread 6 enabled while threads 0-5 are continuously granted -> thread 6 SHALL be granted within 3 cycles of becoming eligible.
REQ-036 flush_i[4] asserted on the same cycle as thread 4's only request -> no grant; entry already registered for thread 4 SHALL still write back.
REQ-037 rst_ni asserted asynchronously mid-stall -> wb_vld_o drops immediately; after release, the grant order SHALL restart from thread 0.
